uart_link_gate: RTL

//  Parametrised successor to the game_over-gated rx->tx pass-through. Accepts received

---
 rtl/uart_link_pkg.sv | 18 +
 rtl/uart_link_gate_if.sv | 23 ++
 rtl/sync_fifo.sv | 54 +++++
 rtl/uart_link_gate.sv | 108 ++++++++++
 4 files changed

// File: rtl/uart_link_pkg.sv
// Shared types and constants for the UART link gate: FSM state encoding,
// default disarm character and the FIFO occupancy width helper.
package uart_link_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_DRAIN = 2'd2
  } link_state_e;

  localparam logic [7:0] DISARM_CHAR_DEF = 8'h1B;

  // Occupancy must represent 0..DEPTH inclusive, hence one extra bit.
  function automatic int count_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/uart_link_gate_if.sv
// Byte-stream bundle between UART receiver, link gate and UART transmitter.
interface uart_link_gate_if #(
  parameter int DATA_W = 8
) ();
  // rx_valid is a one-cycle strobe with no back-pressure: a byte not taken is lost.
  // wr_uart is asserted only while tx_full is low, and w_data is valid in that cycle.
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              game_over;
  logic              tx_full;
  logic              wr_uart;
  logic [DATA_W-1:0] w_data;

  modport slave (
    input  rx_data, rx_valid, game_over, tx_full,
    output wr_uart, w_data
  );

  modport master (
    output rx_data, rx_valid, game_over, tx_full,
    input  wr_uart, w_data
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous reset; pushes on full are refused
// unless a pop happens in the same cycle.
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [DATA_W-1:0]        i_data,
  output logic [DATA_W-1:0]        o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              w_do_push;
  logic              w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CW'(DEPTH));
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_data    = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/uart_link_gate.sv
// Gates received UART bytes through a FIFO to the transmitter while armed.
// Define UART_LINK_GATE_ARM_TIMEOUT_EN to auto-disarm after TIMEOUT idle cycles.
module uart_link_gate
  import uart_link_pkg::*;
#(
  parameter int                DATA_W      = 8,
  parameter int                DEPTH       = 16,
  parameter int                NCHAR       = 2,
  parameter logic [DATA_W-1:0] DISARM_CHAR = DATA_W'(DISARM_CHAR_DEF),
  parameter int                TIMEOUT     = 50_000_000
) (
  input  logic                        clk,
  input  logic                        rst,
  uart_link_gate_if.slave             bus,
  output logic                        o_armed,
  output logic [count_w(DEPTH)-1:0]   o_fifo_count,
  output logic                        o_overflow,
  output logic [DATA_W*NCHAR-1:0]     o_char_hist,
  output link_state_e                 o_state
);
  link_state_e                  r_state;
  link_state_e                  w_next;
  logic                         r_overflow;
  logic [DATA_W*NCHAR-1:0]      r_hist;
  logic                         w_disarm_hit;
  logic                         w_push;
  logic                         w_wr;
  logic                         w_full;
  logic                         w_empty;
  logic                         w_timeout;
  logic [DATA_W-1:0]            w_head;

  assign w_disarm_hit = bus.rx_valid && (bus.rx_data == DISARM_CHAR);
  assign w_push       = bus.rx_valid && (r_state == ST_ARMED) && !w_disarm_hit;
  assign w_wr         = (r_state != ST_IDLE) && !w_empty && !bus.tx_full;

  sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_wr),
    .i_data  (bus.rx_data),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (o_fifo_count)
  );

`ifdef UART_LINK_GATE_ARM_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] r_idle_cnt;

  // Cleared on the firing cycle too, so a simultaneous game_over re-arms a fresh window.
  always_ff @(posedge clk) begin
    if (rst || r_state != ST_ARMED || bus.rx_valid || w_wr || w_timeout) r_idle_cnt <= '0;
    else r_idle_cnt <= r_idle_cnt + TW'(1);
  end
  assign w_timeout = (r_state == ST_ARMED) && !bus.rx_valid && !w_wr &&
                     (r_idle_cnt == TW'(TIMEOUT - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // game_over wins over disarm/timeout in every state.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (bus.game_over) w_next = ST_ARMED;
      ST_ARMED: begin
        if (bus.game_over)                  w_next = ST_ARMED;
        else if (w_disarm_hit || w_timeout) w_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (bus.game_over)          w_next = ST_ARMED;
        else if (w_empty && !w_push) w_next = ST_IDLE;
      end
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)                             r_overflow <= 1'b0;
    else if (w_push && w_full && !w_wr)  r_overflow <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hist <= '0;
    end else if (bus.rx_valid) begin
      for (int i = NCHAR - 1; i > 0; i--) begin
        r_hist[i*DATA_W +: DATA_W] <= r_hist[(i-1)*DATA_W +: DATA_W];
      end
      r_hist[DATA_W-1:0] <= bus.rx_data;
    end
  end

  assign bus.wr_uart = w_wr;
  assign bus.w_data  = w_empty ? '0 : w_head;
  assign o_armed     = (r_state != ST_IDLE);
  assign o_overflow  = r_overflow;
  assign o_char_hist = r_hist;
  assign o_state     = r_state;
endmodule
